capture_seq_ctrl: RTL and testbench

CAPTURE_SEQ_CTRL -- requirements
Module: capture_seq_ctrl

---
 rtl/capture_seq_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_capture_seq_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_seq_ctrl.sv
// -----------------------------------------------------------------------------
// capture_seq_ctrl
//
// Read sequencer for a multi-channel capture memory. A start (from IDLE) or a
// re-read request (from DONE) launches one pass. A pass waits a configurable
// gap, then reads every word of every channel in ascending address order. The
// words are framed into packets of L words, and a configurable idle time is
// inserted between packets. The pass configuration is latched when the
// request is accepted, so the config inputs may change freely during a pass.
//
// Parameters
//   DEPTH   words per channel (multiple of 1728)
//   CH_NUM  number of capture channels (>= 1)
//   ADDR_W  read address width (2^ADDR_W >= DEPTH)
//   CNT_W   pass counter width
//
// Ports
//   clk, rstn          single clock, asynchronous active-low reset
//   capture_start      start request, honoured in IDLE and DONE
//   capture_again      re-read request, honoured in DONE only
//   pkt_data_length    packet length code, L = 216 << code
//   pktctrl_gap        pre-read gap G (GAP lasts G+1 cycles)
//   pkt_idle_length    inter-packet idle I (0 = back-to-back packets)
//   rd_en/rd_addr/rd_ch  memory read strobe, word address, channel select
//   pkt_sop/pkt_eop    first / last word of the current packet
//   curr_sta           FSM state code
//   busy               pass in progress (GAP, READ or PKT_IDLE)
//   rd_done            one-cycle pulse when the pass completes
//   pass_cnt           completed passes, saturating
//
// Every output is either a flop or a decode of flops only. No input reaches
// an output without passing through a register.
// -----------------------------------------------------------------------------
module capture_seq_ctrl #(
  parameter  int DEPTH  = 3456,
  parameter  int CH_NUM = 2,
  parameter  int ADDR_W = 12,
  parameter  int CNT_W  = 4,
  localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              capture_start,
  input  logic              capture_again,
  input  logic [1:0]        pkt_data_length,
  input  logic [7:0]        pktctrl_gap,
  input  logic [7:0]        pkt_idle_length,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [CH_W-1:0]   rd_ch,
  output logic              pkt_sop,
  output logic              pkt_eop,
  output logic [2:0]        curr_sta,
  output logic              busy,
  output logic              rd_done,
  output logic [CNT_W-1:0]  pass_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GAP      = 3'd1,
    S_READ     = 3'd2,
    S_PKT_IDLE = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Largest packet is 1728 words, so an 11-bit word index is enough.
  localparam int WIDX_W = 11;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(CH_NUM - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t              state,    state_d;
  logic [WIDX_W-1:0]   word_idx, word_idx_d;   // word index inside the packet
  logic [7:0]          gap_cnt,  gap_cnt_d;    // GAP cycles still to go after this one
  logic [7:0]          idle_cnt, idle_cnt_d;   // PKT_IDLE cycles still to go after this one
  logic [1:0]          len_q,    len_q_d;      // latched packet length code
  logic [7:0]          idle_q,   idle_q_d;     // latched inter-packet idle length
  logic [ADDR_W-1:0]   rd_addr_d;
  logic [CH_W-1:0]     rd_ch_d;
  logic                rd_done_d;
  logic [CNT_W-1:0]    pass_cnt_d;

  // ---------------------------------------------------------------------------
  // Derived terms
  // ---------------------------------------------------------------------------
  logic [WIDX_W-1:0] pkt_last;    // index of the eop word, L-1
  logic              last_word;
  logic              last_addr;
  logic              last_ch;
  logic              accept;

  assign pkt_last  = (WIDX_W'(216) << len_q) - WIDX_W'(1);
  assign last_word = (word_idx == pkt_last);
  assign last_addr = (rd_addr == LAST_ADDR);
  assign last_ch   = (rd_ch == LAST_CH);

  // Requests are only looked at in IDLE and DONE. Anything arriving while busy
  // is dropped, and the latched configuration stays untouched.
  assign accept = ((state == S_IDLE) && capture_start) ||
                  ((state == S_DONE) && (capture_start || capture_again));

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state;
    word_idx_d = word_idx;
    gap_cnt_d  = gap_cnt;
    idle_cnt_d = idle_cnt;
    len_q_d    = len_q;
    idle_q_d   = idle_q;
    rd_addr_d  = rd_addr;
    rd_ch_d    = rd_ch;
    rd_done_d  = 1'b0;
    pass_cnt_d = pass_cnt;

    unique case (state)
      S_IDLE, S_DONE: begin
        // Both states leave only through 'accept', handled below.
      end

      S_GAP: begin
        if (gap_cnt == 8'd0) begin
          state_d = S_READ;
        end else begin
          gap_cnt_d = gap_cnt - 8'd1;
        end
      end

      S_READ: begin
        if (last_word) begin
          word_idx_d = '0;
          if (last_addr && last_ch) begin
            // Final word of the final channel: the pass ends here.
            state_d    = S_DONE;
            rd_done_d  = 1'b1;
            pass_cnt_d = (pass_cnt == '1) ? pass_cnt : pass_cnt + CNT_W'(1);
          end else begin
            if (last_addr) begin
              rd_ch_d   = rd_ch + CH_W'(1);
              rd_addr_d = '0;
            end else begin
              rd_addr_d = rd_addr + ADDR_W'(1);
            end
            // A zero idle length chains straight into the next packet. A
            // non-zero one spends exactly idle_q cycles in PKT_IDLE, counting
            // down to zero.
            if (idle_q == 8'd0) begin
              state_d = S_READ;
            end else begin
              state_d    = S_PKT_IDLE;
              idle_cnt_d = idle_q - 8'd1;
            end
          end
        end else begin
          word_idx_d = word_idx + WIDX_W'(1);
          rd_addr_d  = rd_addr + ADDR_W'(1);
        end
      end

      S_PKT_IDLE: begin
        if (idle_cnt == 8'd0) begin
          state_d = S_READ;
        end else begin
          idle_cnt_d = idle_cnt - 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d    = S_GAP;
      word_idx_d = '0;
      rd_addr_d  = '0;
      rd_ch_d    = '0;
      len_q_d    = pkt_data_length;
      gap_cnt_d  = pktctrl_gap;
      idle_q_d   = pkt_idle_length;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      word_idx <= '0;
      gap_cnt  <= '0;
      idle_cnt <= '0;
      len_q    <= '0;
      idle_q   <= '0;
      rd_addr  <= '0;
      rd_ch    <= '0;
      rd_done  <= 1'b0;
      pass_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples the
      // pre-edge values and the update order inside the block cannot matter.
      state    <= state_d;
      word_idx <= word_idx_d;
      gap_cnt  <= gap_cnt_d;
      idle_cnt <= idle_cnt_d;
      len_q    <= len_q_d;
      idle_q   <= idle_q_d;
      rd_addr  <= rd_addr_d;
      rd_ch    <= rd_ch_d;
      rd_done  <= rd_done_d;
      pass_cnt <= pass_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (registers only, so outputs still change only on clk/rstn)
  // ---------------------------------------------------------------------------
  assign curr_sta = state;
  assign rd_en    = (state == S_READ);
  assign pkt_sop  = (state == S_READ) && (word_idx == '0);
  assign pkt_eop  = (state == S_READ) && last_word;
  assign busy     = (state == S_GAP) || (state == S_READ) || (state == S_PKT_IDLE);

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_capture_seq_ctrl
//
// Bench for capture_seq_ctrl. For every pass it first builds the full expected
// per-cycle output trace from the sequencing rules: gap cycles, then packets
// of L words walking each channel from 0 to DEPTH-1, idle cycles between
// packets, and a DONE cycle. The DUT is then compared against that trace one
// cycle at a time. While the DUT is busy, the requests and config inputs are
// driven with random values, which the DUT must ignore. A second, small
// instance (one channel, 1728 words) is used for the pass counter saturation
// test, which needs 17 passes.
// -----------------------------------------------------------------------------
module tb_capture_seq_ctrl;

  localparam int DEPTH    = 3456;
  localparam int CH_NUM   = 2;
  localparam int ADDR_W   = 12;
  localparam int CNT_W    = 4;
  localparam int CH_W     = 1;
  localparam int S_DEPTH  = 1728;
  localparam int S_ADDR_W = 11;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              capture_start = 1'b0;
  logic              capture_again = 1'b0;
  logic [1:0]        pkt_data_length = '0;
  logic [7:0]        pktctrl_gap = '0;
  logic [7:0]        pkt_idle_length = '0;
  logic              rd_en, pkt_sop, pkt_eop, busy, rd_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [CH_W-1:0]   rd_ch;
  logic [2:0]        curr_sta;
  logic [CNT_W-1:0]  pass_cnt;

  logic                start_s = 1'b0;
  logic                again_s = 1'b0;
  logic                rd_en_s, sop_s, eop_s, busy_s, rd_done_s;
  logic [S_ADDR_W-1:0] rd_addr_s;
  logic                rd_ch_s;
  logic [2:0]          curr_sta_s;
  logic [CNT_W-1:0]    pass_cnt_s;

  always #5 clk = ~clk;

  capture_seq_ctrl #(.DEPTH(DEPTH), .CH_NUM(CH_NUM), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .capture_start(capture_start), .capture_again(capture_again),
    .pkt_data_length(pkt_data_length), .pktctrl_gap(pktctrl_gap), .pkt_idle_length(pkt_idle_length),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_ch(rd_ch), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .curr_sta(curr_sta), .busy(busy), .rd_done(rd_done), .pass_cnt(pass_cnt)
  );

  capture_seq_ctrl #(.DEPTH(S_DEPTH), .CH_NUM(1), .ADDR_W(S_ADDR_W), .CNT_W(CNT_W)) dut_s (
    .clk(clk), .rstn(rstn), .capture_start(start_s), .capture_again(again_s),
    .pkt_data_length(pkt_data_length), .pktctrl_gap(pktctrl_gap), .pkt_idle_length(pkt_idle_length),
    .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_ch(rd_ch_s), .pkt_sop(sop_s), .pkt_eop(eop_s),
    .curr_sta(curr_sta_s), .busy(busy_s), .rd_done(rd_done_s), .pass_cnt(pass_cnt_s)
  );

  typedef struct packed {
    logic [2:0]        sta;
    logic              en;
    logic              bz;
    logic              sop;
    logic              eop;
    logic              dn;
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  pc;
  } obs_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_pc = 0;   // passes the model has seen complete since the last reset
  obs_t exp_q[$];

  function automatic obs_t mk(int sta, int en, int bz, int sop, int eop, int dn,
                              int ch, int addr, int pc);
    obs_t v;
    v.sta  = 3'(sta);
    v.en   = 1'(en);
    v.bz   = 1'(bz);
    v.sop  = 1'(sop);
    v.eop  = 1'(eop);
    v.dn   = 1'(dn);
    v.ch   = CH_W'(ch);
    v.addr = ADDR_W'(addr);
    v.pc   = CNT_W'(pc);
    return v;
  endfunction

  function automatic obs_t observe();
    obs_t v;
    v.sta  = curr_sta;
    v.en   = rd_en;
    v.bz   = busy;
    v.sop  = pkt_sop;
    v.eop  = pkt_eop;
    v.dn   = rd_done;
    v.ch   = rd_ch;
    v.addr = rd_addr;
    v.pc   = pass_cnt;
    return v;
  endfunction

  function automatic string fmt(obs_t v);
    return $sformatf("sta=%0d en=%0b busy=%0b sop=%0b eop=%0b done=%0b ch=%0d addr=%0d cnt=%0d",
                     v.sta, v.en, v.bz, v.sop, v.eop, v.dn, v.ch, v.addr, v.pc);
  endfunction

  // Expected trace, starting with the first cycle after the accepting edge.
  // Outside READ the address and channel hold the next word to be read.
  // After the final word they hold the last address of the last channel.
  task automatic build_trace(input int len_code, input int g, input int idle, input int linger);
    int plen;
    plen = 216 << len_code;
    exp_q.delete();
    for (int k = 0; k <= g; k++) exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, model_pc));
    for (int c = 0; c < CH_NUM; c++) begin
      for (int a = 0; a < DEPTH; a++) begin
        exp_q.push_back(mk(2, 1, 1, (a % plen) == 0, (a % plen) == plen - 1, 0, c, a, model_pc));
        if ((a % plen) == plen - 1 && !(c == CH_NUM - 1 && a == DEPTH - 1)) begin
          for (int k = 0; k < idle; k++)
            exp_q.push_back(mk(3, 0, 1, 0, 0, 0, (a == DEPTH - 1) ? c + 1 : c,
                               (a == DEPTH - 1) ? 0 : a + 1, model_pc));
        end
      end
    end
    model_pc = (model_pc < CNT_MAX) ? model_pc + 1 : CNT_MAX;
    exp_q.push_back(mk(4, 0, 0, 0, 0, 1, CH_NUM - 1, DEPTH - 1, model_pc));
    for (int k = 0; k < linger; k++)
      exp_q.push_back(mk(4, 0, 0, 0, 0, 0, CH_NUM - 1, DEPTH - 1, model_pc));
  endtask

  task automatic resync();
    rstn = 1'b0;
    capture_start = 1'b0;
    capture_again = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    model_pc = 0;
  endtask

  // Called #1 after the accepting edge. Drives random traffic while the
  // expected state is busy, and drives quiet inputs once the state is DONE.
  task automatic check_trace(input string name);
    obs_t o, e;
    int   bad;
    bad = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      o = observe();
      e = exp_q[k];
      n_checks++;
      if (o !== e) begin
        n_fail++;
        bad++;
        $display("FAIL %s cycle %0d: got %s, expected %s", name, k, fmt(o), fmt(e));
        if (bad >= 8) break;
      end
      if (e.sta != 3'd4) begin
        capture_start   = 1'($urandom_range(0, 1));
        capture_again   = 1'($urandom_range(0, 1));
        pkt_data_length = 2'($urandom);
        pktctrl_gap     = 8'($urandom);
        pkt_idle_length = 8'($urandom);
      end else begin
        capture_start = 1'b0;
        capture_again = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    if (bad >= 8) resync();
  endtask

  task automatic run_pass(input string name, input int len_code, input int g, input int idle,
                          input logic st, input logic ag, input int linger);
    build_trace(len_code, g, idle, linger);
    pkt_data_length = 2'(len_code);
    pktctrl_gap     = 8'(g);
    pkt_idle_length = 8'(idle);
    capture_start   = st;
    capture_again   = ag;
    @(posedge clk);
    #1;
    check_trace(name);
  endtask

  task automatic test_reset();
    rstn          = 1'b0;
    capture_again = 1'b1;   // ignored in IDLE, both during and after reset
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (observe() !== obs_t'(0)) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %s, expected all zero", k, fmt(observe()));
      end
    end
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (observe() !== obs_t'(0)) begin
        n_fail++;
        $display("FAIL idle_again cycle %0d: got %s, expected all zero", k, fmt(observe()));
      end
    end
    capture_again = 1'b0;
    model_pc      = 0;
  endtask

  task automatic test_start();
    run_pass("start_len3_gap4", 3, 4, 0, 1'b1, 1'b0, 2);
  endtask

  task automatic test_again();
    run_pass("again_repeat", 3, 4, 0, 1'b0, 1'b1, 1);
  endtask

  task automatic test_short_packets();
    // Both requests at once from DONE behave like a single one.
    run_pass("len0_idle2_both", 0, 0, 2, 1'b1, 1'b1, 1);
  endtask

  task automatic test_random_pass();
    int lc, g, i;
    lc = $urandom_range(0, 3);
    g  = $urandom_range(0, 255);
    i  = $urandom_range(0, 6);
    run_pass($sformatf("random_len%0d_gap%0d_idle%0d", lc, g, i), lc, g, i, 1'b0, 1'b1, 1);
  endtask

  task automatic test_reset_mid_pass();
    bit hit;
    hit = 1'b0;
    pkt_data_length = 2'd3;
    pktctrl_gap     = 8'd0;
    pkt_idle_length = 8'd0;
    capture_start   = 1'b1;
    @(posedge clk);
    #1 capture_start = 1'b0;
    for (int t = 0; t < 1200 && !hit; t++) begin
      if (rd_en && rd_addr == ADDR_W'(1000) && rd_ch == '0) hit = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL mid_pass_wait: got addr=%0d ch=%0d, expected to reach addr=1000 ch=0", rd_addr, rd_ch);
    end
    // A start request held high through reset is taken on the first edge after release.
    rstn          = 1'b0;
    capture_start = 1'b1;
    #1;
    n_checks++;
    if (observe() !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL async_reset: got %s, expected all zero", fmt(observe()));
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (observe() !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_with_start: got %s, expected all zero", fmt(observe()));
    end
    model_pc = 0;
    build_trace(3, 4, 0, 1);
    pktctrl_gap = 8'd4;
    rstn        = 1'b1;
    @(posedge clk);
    #1;
    check_trace("restart_after_reset");
  endtask

  task automatic test_saturation();
    int  reads, want;
    bit  got;
    pkt_data_length = 2'd3;
    pktctrl_gap     = 8'd0;
    pkt_idle_length = 8'd0;
    for (int p = 0; p < 17; p++) begin
      if (p == 0) start_s = 1'b1;
      else        again_s = 1'b1;
      @(posedge clk);
      #1;
      start_s = 1'b0;
      again_s = 1'b0;
      reads = 0;
      got   = 1'b0;
      for (int t = 0; t < 1800 && !got; t++) begin
        if (rd_en_s) reads++;
        if (rd_done_s) got = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      want = (p + 1 < CNT_MAX) ? p + 1 : CNT_MAX;
      n_checks++;
      if (!got || reads != S_DEPTH || pass_cnt_s !== CNT_W'(want)) begin
        n_fail++;
        $display("FAIL sat_pass%0d: got done=%0b reads=%0d cnt=%0d, expected done=1 reads=%0d cnt=%0d",
                 p, got, reads, pass_cnt_s, S_DEPTH, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_again();
    test_short_packets();
    test_random_pass();
    test_reset_mid_pass();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
